event_encoder: RTL and testbench

Parametrised, registered successor to the combinational 8-to-3 one-hot encoder. Accepts N asynchronous-in-time event lines, latches each event as a pending bit, and emits the binary index of one pending event at a time over a valid/ready stream. Supports fixed-priority and round-robin selection, and reports events that arrive while the same index is already pending. Used wherever multi-hot or bursty request vectors must be serialised into a binary index stream, such as interrupt and event collection.

---
 rtl/event_enc_pkg.sv | 12 +
 rtl/prio_select.sv | 38 +++
 rtl/event_encoder.sv | 94 +++++++++
 tb/tb_event_encoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/event_enc_pkg.sv
// Shared constants and helpers for the event encoder and its selector.
// Selection modes plus the index-width helper used to size ports.
package event_enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_select.sv
// Combinational first-set-bit search over a request vector.
// The search starts at a rotating base, or at index 0 in fixed-priority mode.
module prio_select
    import event_enc_pkg::*;
#(
    parameter int  N    = 8,
    parameter int  MODE = MODE_FIXED,
    localparam int W    = idx_width(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] base;
    logic [W:0]   pos;

    assign base = (MODE == MODE_RR) ? start : '0;

    // One extra bit on pos lets base+k exceed N before the wrap back into range.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, base} + (W+1)'(k);
            if (pos >= (W+1)'(N)) begin
                pos = pos - (W+1)'(N);
            end
            if (!found && vec[pos[W-1:0]]) begin
                found = 1'b1;
                idx   = pos[W-1:0];
            end
        end
    end

endmodule

// File: rtl/event_encoder.sv
// Latches event lines as pending bits and streams their indices out over valid/ready.
// Selection is either fixed priority or round robin, depending on MODE.
module event_encoder
    import event_enc_pkg::*;
#(
    parameter int  N    = 8,
    parameter int  MODE = MODE_FIXED,
    localparam int W    = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic [W:0]   pend_cnt,
    output logic         overrun
);

    logic [N-1:0] pending_q, pending_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W:0]   pend_cnt_q, pend_cnt_d;
    logic         overrun_q, overrun_d;

    logic [N-1:0] p_vec;
    logic         load;
    logic         sel_found;
    logic [W-1:0] sel_idx;

    assign p_vec = pending_q | req;
    assign load  = !out_valid_q || out_ready;

    prio_select #(
        .N    (N),
        .MODE (MODE)
    ) u_select (
        .vec   (p_vec),
        .start (ptr_q),
        .found (sel_found),
        .idx   (sel_idx)
    );

    always_comb begin
        pending_d   = p_vec;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        ptr_d       = ptr_q;
        overrun_d   = |(req & pending_q);
        if (load) begin
            out_valid_d = sel_found;
            if (sel_found) begin
                out_idx_d = sel_idx;
                pending_d = p_vec & ~(N'(1) << sel_idx);
                ptr_d     = (sel_idx == W'(N - 1)) ? '0 : sel_idx + W'(1);
            end
        end
    end

    // Count from the next-state vector so pend_cnt lands in the same edge as pending.
    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < N; i++) begin
            pend_cnt_d = pend_cnt_d + (W+1)'(pending_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            ptr_q       <= '0;
            pend_cnt_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            ptr_q       <= ptr_d;
            pend_cnt_q  <= pend_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;
    assign pend_cnt  = pend_cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_event_encoder.sv
// Bench for event_encoder: three instances (N=8 fixed, N=8 round robin, N=5 round robin).
// Each instance is checked every cycle against a behavioural model, and against directed expectations.
module tb_event_encoder;

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       exp_valid;
        int         exp_idx;
        logic [7:0] exp_pend;
        int         exp_cnt;
        logic       exp_ovr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req0, req1;
    logic [4:0] req2;
    logic       rdy0, rdy1, rdy2;
    logic       v0, v1, v2;
    logic [2:0] idx0, idx1, idx2;
    logic [7:0] pend0, pend1;
    logic [4:0] pend2;
    logic [3:0] cnt0, cnt1, cnt2;
    logic       ovr0, ovr1, ovr2;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: one row per instance.
    int m_n[3]    = '{8, 8, 5};
    int m_mode[3] = '{0, 1, 1};
    bit m_pend[3][8];
    bit m_valid[3];
    int m_idx[3];
    int m_ptr[3];
    bit m_ovr[3];

    vec_t tbl[$];

    always #5 clk = ~clk;

    event_encoder #(.N(8), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .out_ready(rdy0), .out_valid(v0),
        .out_idx(idx0), .pending(pend0), .pend_cnt(cnt0), .overrun(ovr0));

    event_encoder #(.N(8), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .out_ready(rdy1), .out_valid(v1),
        .out_idx(idx1), .pending(pend1), .pend_cnt(cnt1), .overrun(ovr1));

    event_encoder #(.N(5), .MODE(1)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .out_ready(rdy2), .out_valid(v2),
        .out_idx(idx2), .pending(pend2), .pend_cnt(cnt2), .overrun(ovr2));

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) m_pend[d][i] = 1'b0;
            m_valid[d] = 1'b0;
            m_idx[d]   = 0;
            m_ptr[d]   = 0;
            m_ovr[d]   = 1'b0;
        end
    endfunction

    // Merge new events, then hand out one index if the slot is free or being taken.
    function automatic void model_edge(input int d, input int rq, input bit rdy);
        bit p[8];
        bit ovr;
        int sel;
        int start;
        ovr = 1'b0;
        sel = -1;
        for (int i = 0; i < 8; i++) begin
            p[i] = (i < m_n[d]) && (m_pend[d][i] || ((rq >> i) & 1) == 1);
            if (i < m_n[d] && m_pend[d][i] && ((rq >> i) & 1) == 1) ovr = 1'b1;
        end
        if (!m_valid[d] || rdy) begin
            start = (m_mode[d] == 1) ? m_ptr[d] : 0;
            for (int k = 0; k < m_n[d]; k++) begin
                if (sel < 0 && p[(start + k) % m_n[d]]) sel = (start + k) % m_n[d];
            end
            m_valid[d] = (sel >= 0);
            if (sel >= 0) begin
                m_idx[d] = sel;
                p[sel]   = 1'b0;
                m_ptr[d] = (sel + 1) % m_n[d];
            end
        end
        for (int i = 0; i < 8; i++) m_pend[d][i] = p[i];
        m_ovr[d] = ovr;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] r0, input logic [7:0] r1, input logic [4:0] r2,
                                 input logic y0, input logic y1, input logic y2);
        req0 = r0;
        req1 = r1;
        req2 = r2;
        rdy0 = y0;
        rdy1 = y1;
        rdy2 = y2;
    endtask

    task automatic compareAll();
        int mp, mc, dv, di, dp, dc, dov;
        for (int d = 0; d < 3; d++) begin
            mp = 0;
            mc = 0;
            for (int i = 0; i < m_n[d]; i++) begin
                if (m_pend[d][i]) begin
                    mp = mp | (1 << i);
                    mc++;
                end
            end
            case (d)
                0:       begin dv = v0; di = idx0; dp = pend0; dc = cnt0; dov = ovr0; end
                1:       begin dv = v1; di = idx1; dp = pend1; dc = cnt1; dov = ovr1; end
                default: begin dv = v2; di = idx2; dp = pend2; dc = cnt2; dov = ovr2; end
            endcase
            checkOutput($sformatf("model d%0d out_valid", d), dv, int'(m_valid[d]));
            checkOutput($sformatf("model d%0d out_idx", d), di, m_idx[d]);
            checkOutput($sformatf("model d%0d pending", d), dp, mp);
            checkOutput($sformatf("model d%0d pend_cnt", d), dc, mc);
            checkOutput($sformatf("model d%0d overrun", d), dov, int'(m_ovr[d]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            model_edge(0, int'(req0), rdy0);
            model_edge(1, int'(req1), rdy1);
            model_edge(2, int'(req2), rdy2);
        end
        #1;
        compareAll();
    endtask

    function automatic void addRow(input logic [7:0] r, input logic y, input logic ev, input int ei,
                                   input logic [7:0] ep, input int ec, input logic eo);
        vec_t v;
        v.req = r; v.rdy = y; v.exp_valid = ev; v.exp_idx = ei;
        v.exp_pend = ep; v.exp_cnt = ec; v.exp_ovr = eo;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [7:0] mask;

        // Directed vectors for the fixed-priority instance, starting right after reset release.
        addRow(8'hFF, 1, 1, 0, 8'hFE, 7, 0);
        for (int k = 1; k < 8; k++) begin
            mask = 8'hFF;
            addRow(8'h00, 1, 1, k, mask << (k + 1), 7 - k, 0);
        end
        addRow(8'h00, 1, 0, 7, 8'h00, 0, 0);
        for (int k = 0; k < 8; k++) begin
            mask = 8'h01;
            addRow(mask << k, 1, 1, k, 8'h00, 0, 0);
        end
        addRow(8'h00, 1, 0, 7, 8'h00, 0, 0);
        addRow(8'hA5, 1, 1, 0, 8'hA4, 3, 0);
        addRow(8'h00, 1, 1, 2, 8'hA0, 2, 0);
        addRow(8'h00, 1, 1, 5, 8'h80, 1, 0);
        addRow(8'h00, 1, 1, 7, 8'h00, 0, 0);
        addRow(8'h00, 1, 0, 7, 8'h00, 0, 0);
        addRow(8'h10, 0, 1, 4, 8'h00, 0, 0);
        addRow(8'h02, 0, 1, 4, 8'h02, 1, 0);
        addRow(8'h02, 0, 1, 4, 8'h02, 1, 1);
        addRow(8'h10, 0, 1, 4, 8'h12, 2, 0);
        addRow(8'h00, 1, 1, 1, 8'h10, 1, 0);
        addRow(8'h00, 1, 1, 4, 8'h00, 0, 0);
        addRow(8'h00, 1, 0, 4, 8'h00, 0, 0);

        // Reset with every line asserted: nothing may leak through.
        rst = 1'b1;
        applyStimulus(8'hFF, 8'hFF, 5'h1F, 1, 1, 1);
        for (int c = 0; c < 2; c++) begin
            tick();
            checkOutput("reset out_valid", int'(v0), 0);
            checkOutput("reset out_idx", int'(idx0), 0);
            checkOutput("reset pending", int'(pend0), 0);
            checkOutput("reset pend_cnt", int'(cnt0), 0);
            checkOutput("reset overrun", int'(ovr0), 0);
            checkOutput("reset rr out_valid", int'(v1), 0);
            checkOutput("reset n5 out_valid", int'(v2), 0);
        end
        rst = 1'b0;

        foreach (tbl[k]) begin
            applyStimulus(tbl[k].req, 8'h00, 5'h00, tbl[k].rdy, 1, 1);
            tick();
            checkOutput($sformatf("tbl[%0d] out_valid", k), int'(v0), int'(tbl[k].exp_valid));
            checkOutput($sformatf("tbl[%0d] out_idx", k), int'(idx0), tbl[k].exp_idx);
            checkOutput($sformatf("tbl[%0d] pending", k), int'(pend0), int'(tbl[k].exp_pend));
            checkOutput($sformatf("tbl[%0d] pend_cnt", k), int'(cnt0), tbl[k].exp_cnt);
            checkOutput($sformatf("tbl[%0d] overrun", k), int'(ovr0), int'(tbl[k].exp_ovr));
        end

        // Round robin with both ends held high: indices alternate, re-requests flag overrun.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(8'h00, 8'h81, 5'h00, 1, 1, 1);
            tick();
            checkOutput($sformatf("rr[%0d] out_valid", k), int'(v1), 1);
            checkOutput($sformatf("rr[%0d] out_idx", k), int'(idx1), (k % 2 == 0) ? 0 : 7);
            checkOutput($sformatf("rr[%0d] overrun", k), int'(ovr1), (k > 0) ? 1 : 0);
        end
        applyStimulus(8'h00, 8'h00, 5'h00, 1, 1, 1);
        tick();
        checkOutput("rr drain out_idx", int'(idx1), 0);
        checkOutput("rr drain pending", int'(pend1), 0);
        tick();
        checkOutput("rr idle out_valid", int'(v1), 0);

        // Five lines, round robin: pointer wraps from 4 back to 0.
        applyStimulus(8'h00, 8'h00, 5'b10001, 1, 1, 1);
        tick();
        checkOutput("n5 first out_idx", int'(idx2), 0);
        checkOutput("n5 first pend_cnt", int'(cnt2), 1);
        applyStimulus(8'h00, 8'h00, 5'b00000, 1, 1, 1);
        tick();
        checkOutput("n5 second out_idx", int'(idx2), 4);
        applyStimulus(8'h00, 8'h00, 5'b00001, 1, 1, 1);
        tick();
        checkOutput("n5 wrap out_valid", int'(v2), 1);
        checkOutput("n5 wrap out_idx", int'(idx2), 0);
        applyStimulus(8'h00, 8'h00, 5'b00000, 1, 1, 1);
        tick();
        checkOutput("n5 idle out_valid", int'(v2), 0);

        // Random bursts, stalls and occasional resets against the model.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            applyStimulus(8'($urandom & $urandom & $urandom),
                          8'($urandom & $urandom),
                          5'($urandom & $urandom & $urandom),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 1) != 0));
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
